// File: rtl/nn_pkg.sv
// nn_pkg: Q8.8 constants, layer FSM states and the saturating ReLU shared by the NN datapath.
package nn_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int FRAC = 8;
    localparam int ACC_WIDTH = 40;
    typedef enum logic [2:0] {IDLE, LOAD_B, MAC, DRAIN, WRITE} state_t;
    function automatic logic [DATA_WIDTH-1:0] relu_sat(input logic signed [ACC_WIDTH-1:0] acc);
        logic signed [ACC_WIDTH-1:0] s;
        s = acc >>> FRAC;
        if (s[ACC_WIDTH-1]) return '0;
        // any set bit above the Q8.8 sign position means the positive value overflowed
        if (|s[ACC_WIDTH-2:DATA_WIDTH-1]) return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        return s[DATA_WIDTH-1:0];
    endfunction
endpackage

// File: rtl/mac_pipe.sv
// mac_pipe: registered product, valid pipe and accumulator with bias load.
module mac_pipe
    import nn_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         issue_i,
    input  logic                         bias_ld_i,
    input  logic signed [DATA_WIDTH-1:0] x_i,
    input  logic signed [DATA_WIDTH-1:0] w_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic signed [ACC_WIDTH-1:0]  acc_o
);
    logic                           v1_q, v2_q;
    logic signed [2*DATA_WIDTH-1:0] p_q;
    logic signed [ACC_WIDTH-1:0]    acc_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            p_q   <= '0;
            acc_q <= '0;
        end else begin
            v1_q <= issue_i;
            v2_q <= v1_q;
            if (v1_q) p_q <= (2*DATA_WIDTH)'(x_i) * (2*DATA_WIDTH)'(w_i);
            // bias lands while the first product is still in flight, so it never races an add
            if (bias_ld_i) acc_q <= ACC_WIDTH'(b_i) <<< FRAC;
            else if (v2_q) acc_q <= acc_q + ACC_WIDTH'(p_q);
        end
    end
    assign acc_o = acc_q;
endmodule

// File: rtl/layer_mac.sv
// layer_mac: fully-connected layer sweep; per neuron loads bias, streams N_IN MACs, writes ReLU-saturated result.
module layer_mac
    import nn_pkg::*;
#(
    parameter int N_IN         = 784,
    parameter int N_OUT        = 16,
    parameter int X_ADDR_WIDTH = 10,
    parameter int W_ADDR_WIDTH = 14,
    parameter int Y_ADDR_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [X_ADDR_WIDTH-1:0] x_addr,
    input  logic [DATA_WIDTH-1:0]   x_q,
    output logic [W_ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0]   w_q,
    output logic [Y_ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]   b_q,
    output logic [Y_ADDR_WIDTH-1:0] y_addr,
    output logic [DATA_WIDTH-1:0]   y_d,
    output logic                    y_we
);
    state_t                   state_q, state_d;
    logic [Y_ADDR_WIDTH-1:0]  n_q, n_d;
    logic [X_ADDR_WIDTH-1:0]  i_q, i_d;
    logic [W_ADDR_WIDTH-1:0]  wa_q, wa_d, nbase_q, nbase_d;
    logic                     dr_q, dr_d, done_q, done_d;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                     i_last, n_last;
    assign i_last = i_q == X_ADDR_WIDTH'(N_IN - 1);
    assign n_last = n_q == Y_ADDR_WIDTH'(N_OUT - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            i_q     <= '0;
            wa_q    <= '0;
            nbase_q <= '0;
            dr_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            wa_q    <= wa_d;
            nbase_q <= nbase_d;
            dr_q    <= dr_d;
            done_q  <= done_d;
        end
    end
    // counters only move on entry to the state that drives them, so addresses hold otherwise
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        wa_d    = wa_q;
        nbase_d = nbase_q;
        dr_d    = dr_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = LOAD_B;
                n_d     = '0;
                nbase_d = '0;
            end
            LOAD_B: begin
                state_d = MAC;
                i_d     = '0;
                wa_d    = nbase_q;
            end
            MAC: if (i_last) begin
                state_d = DRAIN;
                dr_d    = 1'b0;
            end else begin
                i_d  = i_q + X_ADDR_WIDTH'(1);
                wa_d = wa_q + W_ADDR_WIDTH'(1);
            end
            DRAIN: begin
                dr_d    = 1'b1;
                state_d = dr_q ? WRITE : DRAIN;
            end
            WRITE: if (n_last) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = LOAD_B;
                n_d     = n_q + Y_ADDR_WIDTH'(1);
                nbase_d = nbase_q + W_ADDR_WIDTH'(N_IN);
            end
            default: state_d = IDLE;
        endcase
    end
    mac_pipe u_pipe (
        .clk      (clk),
        .rst      (rst),
        .issue_i  (state_q == MAC),
        .bias_ld_i(state_q == MAC && i_q == '0),
        .x_i      (x_q),
        .w_i      (w_q),
        .b_i      (b_q),
        .acc_o    (acc)
    );
    assign busy   = state_q != IDLE;
    assign done   = done_q;
    assign x_addr = i_q;
    assign w_addr = wa_q;
    assign b_addr = n_q;
    assign y_addr = n_q;
    assign y_d    = relu_sat(acc);
    assign y_we   = state_q == WRITE;
endmodule

// File: doc/layer_mac.md
# layer_mac

Fully-connected layer engine for the MNIST inference datapath. On `start` it sweeps every output neuron. For each neuron it reads the bias, then streams activation/weight pairs out of the single-port parameter RAMs (1-cycle registered read). It multiply-accumulates in fixed point, applies ReLU with saturation, and writes one result per neuron into the next layer's activation RAM. It sits directly downstream of the weight, bias and activation RAMs and directly upstream of the next layer's activation RAM.

## Interface
- N_IN, 784, inputs per neuron
- N_OUT, 16, neurons in the layer
- DATA_WIDTH, 16, signed Q8.8 word width for activations, weights, biases and outputs
- FRAC, 8, fractional bits
- ACC_WIDTH, 40, signed accumulator width
- X_ADDR_WIDTH, 10, activation RAM address width
- W_ADDR_WIDTH, 14, weight RAM address width (must cover N_IN*N_OUT)
- Y_ADDR_WIDTH, 4, bias/output address width (must cover N_OUT)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle request; ignored while busy
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse when the last output has been written
- x_addr  out  X_ADDR_WIDTH  activation RAM address
- x_q  in  DATA_WIDTH  activation data, valid 1 cycle after x_addr
- w_addr  out  W_ADDR_WIDTH  weight RAM address, = n*N_IN + i
- w_q  in  DATA_WIDTH  weight data, valid 1 cycle after w_addr
- b_addr  out  Y_ADDR_WIDTH  bias RAM address
- b_q  in  DATA_WIDTH  bias data, valid 1 cycle after b_addr
- y_addr  out  Y_ADDR_WIDTH  output RAM address
- y_d  out  DATA_WIDTH  output data
- y_we  out  1  output write enable

## Operation
- States and transitions:
  - IDLE: start → LOAD_B, with n=0.
  - LOAD_B (1 cycle): drive b_addr=n → MAC.
  - MAC (N_IN cycles, i=0..N_IN-1): drive x_addr=i and w_addr=n*N_IN+i → DRAIN.
  - DRAIN (2 cycles): flush the pipeline → WRITE.
  - WRITE (1 cycle): y_we=1, y_addr=n, y_d=result. If n==N_OUT-1 → IDLE and pulse done; otherwise n+1 → LOAD_B.
- Pipeline:
  - Stage 1 (issue): address driven.
  - Stage 2 (RAM data): product p = x_q*w_q, signed 2*DATA_WIDTH, registered.
  - Stage 3: acc += sign-extend(p).
  - A valid bit travels alongside each stage; acc adds only when it is set.
- Bias load: at the end of MAC cycle 0, acc <= sign-extend(b_q) << FRAC. This overwrites acc. The first product is accumulated at the end of MAC cycle 2. The last product is accumulated at the end of DRAIN cycle 1.
- Result:
  - s = acc >>> FRAC (arithmetic shift, truncation toward −inf).
  - If s<0, result = 0. If s > 2^(DATA_WIDTH-1)-1, result = 0x7FFF. Otherwise result = s[DATA_WIDTH-1:0].
- Accumulator wraps silently beyond ACC_WIDTH. 40 bits is sufficient for N_IN ≤ 256 full-scale terms; larger layers depend on trained weight range.
- Reset values: busy=0, done=0, y_we=0, state IDLE. All addresses, y_d and acc are 0.
- Address outputs hold their last value outside the states that drive them. Consumers must only use them while the corresponding state is active.

## Timing
- Neuron period: N_IN+4 cycles.
- Accepted start in cycle 0: LOAD_B in cycle 1. The final WRITE occurs in cycle N_OUT*(N_IN+4). done and busy falling occur in cycle N_OUT*(N_IN+4)+1.
- start coincident with done: accepted, and a new run begins with no idle gap.
- start while busy: ignored, no effect.
- rst mid-run: all outputs return to reset values immediately. No further y_we occurs, and no partial result is written. The next start restarts at n=0.
- y_we is high for exactly N_OUT cycles per run, with y_addr 0..N_OUT-1 in order.

## Structure
- A shared package `nn_pkg` holds:
  - the Q8.8 constants (DATA_WIDTH, FRAC),
  - the state enum (IDLE, LOAD_B, MAC, DRAIN, WRITE),
  - the saturating ReLU function.
- One sub-module, `mac_pipe`: product register, valid pipe, accumulator with bias-load and add controls.
- The FSM and address counters live in the top level.

## Test plan
All scenarios use N_IN=4, N_OUT=2 and behavioural 1-cycle RAM models.
- Reset with no start → busy=0, done=0, y_we=0 and all addresses 0 for 20 cycles.
- x={0x0100,0x0200,0xFF00,0x0080}, w0={0x0100×4}, b0=0x0040 → y[0]=0x02C0 (2.75). done occurs exactly 17 cycles after start.
- w1={0xFF00×4}, b1=0 with the same x → s=−2.5, y[1]=0x0000.
- x={0x7FFF×4}, w0={0x7FFF×4}, b0=0x7FFF → y[0]=0x7FFF (saturation).
- start pulsed during cycle 5 of a run → ignored. rst asserted in MAC cycle 2 → y_we never rises. A restart then reproduces y[0]=0x02C0 and y[1]=0x0000.
- start held high on the done cycle → second run begins the next cycle, and the y_we count over both runs is 4.
